// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: start detection, mid-bit sampling, parity/stop checks.
module rx_frame_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 AcqSig_i,
    input  logic                 Rx_i,
    input  logic                 Enable_i,
    input  logic                 ParityEn_i,
    input  logic                 ParityOdd_i,
    input  logic                 StopBits2_i,
    output logic [4:0]           State_o,
    output logic [3:0]           BitIndex_o,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 DataValid_o,
    output logic                 ParityErr_o,
    output logic                 FrameErr_o,
    output logic                 Busy_o
);

    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_FULL = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00000,
        START  = 5'b00001,
        DATA   = 5'b00010,
        PARITY = 5'b00100,
        STOP   = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 cfg_par_en_q, cfg_par_en_d;
    logic                 cfg_odd_q, cfg_odd_d;
    logic                 cfg_stop2_q, cfg_stop2_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 busy_q, busy_d;
    logic                 sample_c;
    logic                 ferr_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rx_prev_q    <= 1'b1;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            cfg_par_en_q <= 1'b0;
            cfg_odd_q    <= 1'b0;
            cfg_stop2_q  <= 1'b0;
            stop_cnt_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            dv_q         <= 1'b0;
            perr_out_q   <= 1'b0;
            ferr_out_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_prev_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            cfg_par_en_q <= cfg_par_en_d;
            cfg_odd_q    <= cfg_odd_d;
            cfg_stop2_q  <= cfg_stop2_d;
            stop_cnt_q   <= stop_cnt_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            dv_q         <= dv_d;
            perr_out_q   <= perr_out_d;
            ferr_out_q   <= ferr_out_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, sampling and output-load logic
    always_comb begin
        state_d      = state_q;
        rx_prev_d    = rx_prev_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        cfg_par_en_d = cfg_par_en_q;
        cfg_odd_d    = cfg_odd_q;
        cfg_stop2_d  = cfg_stop2_q;
        stop_cnt_d   = stop_cnt_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_q;
        dv_d         = 1'b0;
        perr_out_d   = perr_out_q;
        ferr_out_d   = ferr_out_q;
        sample_c     = 1'b0;
        ferr_c       = ferr_q | ~Rx_i;

        if (AcqSig_i) begin
            rx_prev_d = Rx_i;
        end

        // Mid-bit sample point: half a bit into START, a full bit thereafter
        if (AcqSig_i) begin
            if (state_q == START) begin
                sample_c = (tick_cnt_q == TICK_HALF);
            end else if (state_q == DATA || state_q == PARITY || state_q == STOP) begin
                sample_c = (tick_cnt_q == TICK_FULL);
            end
        end

        case (state_q)
            IDLE: begin
                if (Enable_i && AcqSig_i && rx_prev_q && !Rx_i) begin
                    state_d      = START;
                    cfg_par_en_d = ParityEn_i;
                    cfg_odd_d    = ParityOdd_i;
                    cfg_stop2_d  = StopBits2_i;
                    perr_d       = 1'b0;
                    ferr_d       = 1'b0;
                end
            end
            START: begin
                if (sample_c) begin
                    if (Rx_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_d   = {Rx_i, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = cfg_par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (sample_c) begin
                    perr_d     = (^shift_q) ^ Rx_i ^ cfg_odd_q;
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (sample_c) begin
                    ferr_d = ferr_c;
                    if (cfg_stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = DONE;
                        data_d     = shift_q;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_c;
                        dv_d       = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable discards any partial frame without touching published results
        if (!Enable_i) begin
            state_d    = IDLE;
            data_d     = data_q;
            perr_out_d = perr_out_q;
            ferr_out_d = ferr_out_q;
            dv_d       = 1'b0;
        end

        // Tick counter restarts on every transition and after every sample
        if (state_d != state_q || sample_c) begin
            tick_cnt_d = '0;
        end else if (AcqSig_i) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        busy_d = (state_d != IDLE);
    end

    assign State_o     = state_q;
    assign BitIndex_o  = bit_idx_q;
    assign Data_o      = data_q;
    assign DataValid_o = dv_q;
    assign ParityErr_o = perr_out_q;
    assign FrameErr_o  = ferr_out_q;
    assign Busy_o      = busy_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: serial frames built from bit lists, results from a frame model.
module tb_rx_frame_ctrl;

    localparam int unsigned OS = 16;
    localparam int unsigned DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          AcqSig_i = 1'b0;
    logic          Rx_i = 1'b1;
    logic          Enable_i = 1'b0;
    logic          ParityEn_i = 1'b0;
    logic          ParityOdd_i = 1'b0;
    logic          StopBits2_i = 1'b0;
    logic [4:0]    State_o;
    logic [3:0]    BitIndex_o;
    logic [DB-1:0] Data_o;
    logic          DataValid_o;
    logic          ParityErr_o;
    logic          FrameErr_o;
    logic          Busy_o;

    int            vectors = 0;
    int            errors = 0;
    int            dv_total = 0;
    logic          dv_now;
    logic          tick_dv;
    logic [DB-1:0] exp_data = '0;
    logic          exp_perr = 1'b0;
    logic          exp_ferr = 1'b0;

    rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .AcqSig_i(AcqSig_i), .Rx_i(Rx_i), .Enable_i(Enable_i),
        .ParityEn_i(ParityEn_i), .ParityOdd_i(ParityOdd_i), .StopBits2_i(StopBits2_i),
        .State_o(State_o), .BitIndex_o(BitIndex_o), .Data_o(Data_o),
        .DataValid_o(DataValid_o), .ParityErr_o(ParityErr_o), .FrameErr_o(FrameErr_o),
        .Busy_o(Busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock with the given tick level; outputs are sampled 1 ns after the edge
    task automatic cyc(input logic tk);
        AcqSig_i = tk;
        @(posedge clk);
        #1;
        dv_now = DataValid_o;
        if (DataValid_o === 1'b1) dv_total++;
        AcqSig_i = 1'b0;
    endtask

    // A random gap of tick-less clocks, then one tick carrying the given line level
    task automatic tick(input logic lvl);
        repeat ($urandom_range(0, 2)) cyc(1'b0);
        Rx_i = lvl;
        cyc(1'b1);
        tick_dv = dv_now;
    endtask

    task automatic check_outputs_held(input string name);
        vectors++;
        if (Data_o !== exp_data || ParityErr_o !== exp_perr || FrameErr_o !== exp_ferr)
            begin errors++; $display("FAIL %s held: got data=%0h pe=%0b fe=%0b expected data=%0h pe=%0b fe=%0b",
                name, Data_o, ParityErr_o, FrameErr_o, exp_data, exp_perr, exp_ferr); end
    endtask

    // abort_mode: 0 full frame, 1 reset after 4th data bit, 2 disable while in parity
    task automatic send_frame(input string name, input logic [DB-1:0] d, input logic pe, input logic odd,
                              input logic s2, input logic pflip, input logic [1:0] stop_bad,
                              input int abort_mode);
        logic bits[$];
        logic pbit;
        int   nb;
        int   last_j;
        int   dv_before;
        ParityEn_i  = pe;
        ParityOdd_i = odd;
        StopBits2_i = s2;
        Enable_i    = 1'b1;
        pbit        = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DB); i++) bits.push_back(d[i]);
        if (pe) begin
            pbit = (^d) ^ odd ^ pflip;
            bits.push_back(pbit);
        end
        bits.push_back(~stop_bad[0]);
        if (s2) bits.push_back(~stop_bad[1]);
        nb        = bits.size();
        last_j    = OS / 2 + OS * (nb - 1);
        dv_before = dv_total;

        for (int j = 0; j < nb * int'(OS); j++) begin
            tick(bits[j / OS]);
            if (j == 0) begin
                vectors++;
                if (State_o !== 5'b00001 || Busy_o !== 1'b1)
                    begin errors++; $display("FAIL %s start: got state=%0h busy=%0b expected state=1 busy=1", name, State_o, Busy_o); end
                ParityEn_i  = 1'($urandom_range(0, 1));
                ParityOdd_i = 1'($urandom_range(0, 1));
                StopBits2_i = 1'($urandom_range(0, 1));
            end
            if (abort_mode == 1 && j == int'(OS / 2 + OS * 4)) begin
                vectors++;
                if (State_o !== 5'b00010 || BitIndex_o !== 4'd4)
                    begin errors++; $display("FAIL %s pre-reset: got state=%0h idx=%0d expected state=2 idx=4", name, State_o, BitIndex_o); end
                #2 rst = 1'b0;
                #1;
                exp_data = '0; exp_perr = 1'b0; exp_ferr = 1'b0;
                vectors++;
                if (State_o !== 5'b0 || BitIndex_o !== 4'd0 || Data_o !== '0 || DataValid_o !== 1'b0 ||
                    ParityErr_o !== 1'b0 || FrameErr_o !== 1'b0 || Busy_o !== 1'b0)
                    begin errors++; $display("FAIL %s async reset: got state=%0h idx=%0d data=%0h dv=%0b pe=%0b fe=%0b busy=%0b expected all 0",
                        name, State_o, BitIndex_o, Data_o, DataValid_o, ParityErr_o, FrameErr_o, Busy_o); end
                repeat (3) cyc(1'b1);
                rst  = 1'b1;
                Rx_i = 1'b1;
                repeat (OS) tick(1'b1);
                vectors++;
                if (dv_total != dv_before || State_o !== 5'b0)
                    begin errors++; $display("FAIL %s after reset: got dv=%0d state=%0h expected dv=0 state=0", name, dv_total - dv_before, State_o); end
                return;
            end
            if (abort_mode == 2 && j == int'(OS / 2 + OS * DB)) begin
                vectors++;
                if (State_o !== 5'b00100)
                    begin errors++; $display("FAIL %s in parity: got state=%0h expected 4", name, State_o); end
                Enable_i = 1'b0;
                cyc(1'b0);
                vectors++;
                if (State_o !== 5'b0 || Busy_o !== 1'b0)
                    begin errors++; $display("FAIL %s disable: got state=%0h busy=%0b expected state=0 busy=0", name, State_o, Busy_o); end
                Rx_i     = 1'b1;
                Enable_i = 1'b1;
                repeat (2 * OS) tick(1'b1);
                vectors++;
                if (dv_total != dv_before)
                    begin errors++; $display("FAIL %s disable dv: got %0d pulses expected 0", name, dv_total - dv_before); end
                check_outputs_held(name);
                return;
            end
            if (j == last_j) begin
                vectors++;
                if (tick_dv !== 1'b1)
                    begin errors++; $display("FAIL %s latency: got dv=%0b after stop sample expected 1", name, tick_dv); end
            end
        end

        exp_data = d;
        exp_perr = pe ? ((^d) ^ pbit ^ odd) : 1'b0;
        exp_ferr = stop_bad[0] | (s2 & stop_bad[1]);
        repeat (2) tick(1'b1);
        vectors++;
        if (dv_total - dv_before != 1)
            begin errors++; $display("FAIL %s dv count: got %0d expected 1", name, dv_total - dv_before); end
        vectors++;
        if (Data_o !== exp_data || ParityErr_o !== exp_perr || FrameErr_o !== exp_ferr)
            begin errors++; $display("FAIL %s result: got data=%0h pe=%0b fe=%0b expected data=%0h pe=%0b fe=%0b",
                name, Data_o, ParityErr_o, FrameErr_o, exp_data, exp_perr, exp_ferr); end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        vectors++;
        if (State_o !== 5'b0 || BitIndex_o !== 4'd0 || Data_o !== '0 || DataValid_o !== 1'b0 ||
            ParityErr_o !== 1'b0 || FrameErr_o !== 1'b0 || Busy_o !== 1'b0)
            begin errors++; $display("FAIL reset: got state=%0h idx=%0d data=%0h dv=%0b pe=%0b fe=%0b busy=%0b expected all 0",
                State_o, BitIndex_o, Data_o, DataValid_o, ParityErr_o, FrameErr_o, Busy_o); end
        repeat (3) cyc(1'b0);
        rst = 1'b1;
        repeat (2) cyc(1'b0);
    endtask

    task automatic test_8n1();
        send_frame("8n1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    endtask

    task automatic test_false_start();
        int dv_before;
        dv_before = dv_total;
        Enable_i  = 1'b1;
        for (int j = 0; j < 9; j++) begin
            tick(j < 4 ? 1'b0 : 1'b1);
            if (j == 0 || j == 7) begin
                vectors++;
                if (State_o !== 5'b00001)
                    begin errors++; $display("FAIL false_start tick%0d: got state=%0h expected 1", j, State_o); end
            end
        end
        vectors++;
        if (State_o !== 5'b0 || dv_total != dv_before)
            begin errors++; $display("FAIL false_start end: got state=%0h dv=%0d expected state=0 dv=0", State_o, dv_total - dv_before); end
        check_outputs_held("false_start");
        repeat (4) tick(1'b1);
    endtask

    task automatic test_parity();
        send_frame("parity_err", 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 0);
        send_frame("parity_odd_ok", 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 0);
    endtask

    task automatic test_stop2();
        send_frame("stop2_err", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 0);
    endtask

    task automatic test_reset_mid();
        send_frame("reset_mid", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1);
        send_frame("after_reset", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    endtask

    task automatic test_disable_parity();
        send_frame("pre_disable", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        send_frame("disable_par", 8'h71, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            logic [DB-1:0] d;
            logic [1:0]    sb;
            d  = DB'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame("random", d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), sb, 0);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_false_start();
        test_parity();
        test_stop2();
        test_reset_mid();
        test_disable_parity();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set the AcqSig_i ticks per bit; legal values are even, 4..16.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the data bits per frame; legal values are 5..8.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on posedge clk.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 AcqSig_i  input  1  SHALL be a one-clk-wide sample tick from the baudrate module, at OVERSAMPLE x baud.
REQ-006 Rx_i  input  1  SHALL be the serial line, already synchronized to clk; the idle level is 1.
REQ-007 Enable_i  input  1  SHALL enable the receiver; 0 forces IDLE.
REQ-008 ParityEn_i  input  1  SHALL select a parity bit (1) or no parity bit (0).
REQ-009 ParityOdd_i  input  1  SHALL select odd parity (1) or even parity (0).
REQ-010 StopBits2_i  input  1  SHALL select two stop bits (1) or one stop bit (0).
REQ-011 State_o  output  5  SHALL give the current state code.
REQ-012 BitIndex_o  output  4  SHALL give the index of the data bit being received.
REQ-013 Data_o  output  DATA_BITS  SHALL hold the last completed frame, LSB received first.
REQ-014 DataValid_o  output  1  SHALL pulse high for one clk when a frame completes.
REQ-015 ParityErr_o, FrameErr_o  output  1 each  SHALL give the error flags for the frame in Data_o.
REQ-016 Busy_o  output  1  SHALL be high whenever State_o != IDLE.

Function
REQ-017 States SHALL be encoded IDLE=5'b00000, START=5'b00001, DATA=5'b00010, PARITY=5'b00100, STOP=5'b01000, DONE=5'b10000.
REQ-018 rx_prev SHALL be a 1-bit register of Rx_i, updated only on AcqSig_i.
- A falling edge is rx_prev=1 and Rx_i=0 on a tick.
REQ-019 tick_cnt SHALL be a 4-bit counter that increments only on AcqSig_i.
- It SHALL clear on every state transition.
REQ-020 IDLE to START SHALL occur on a falling edge while Enable_i=1.
REQ-021 START: on the tick where tick_cnt==OVERSAMPLE/2-1, the FSM SHALL sample Rx_i.
- Rx_i=1 is a false start: go to IDLE with no outputs changed.
- Rx_i=0: go to DATA with BitIndex_o=0.
REQ-022 DATA/PARITY/STOP SHALL sample Rx_i on the tick where tick_cnt==OVERSAMPLE-1, i.e. at mid-bit.
REQ-023 DATA: each sample SHALL shift into the MSB of an internal shift register, which shifts right (LSB first), and BitIndex_o SHALL increment.
- After sample DATA_BITS-1 the FSM goes to PARITY if ParityEn_i=1, else to STOP.
REQ-024 PARITY: the parity error SHALL be set when the XOR of the data bits, the parity bit and ParityOdd_i is not 0.
- The FSM then goes to STOP.
REQ-025 STOP: a sampled 0 SHALL set the frame error.
- With StopBits2_i=1, two stop samples SHALL be taken, and either one being 0 sets the frame error.
- After the last stop sample the FSM goes to DONE.
REQ-026 DONE SHALL last exactly one clk, then go to IDLE; in that clk:
- Data_o SHALL load the shift register, right-aligned.
- ParityErr_o and FrameErr_o SHALL load the internal flags.
- DataValid_o SHALL be 1.
REQ-027 Latency SHALL be exactly one clk from the tick of the last stop-bit sample to DataValid_o=1.
REQ-028 Data_o, ParityErr_o and FrameErr_o SHALL hold their values until the next DONE.
REQ-029 The internal error flags SHALL clear on entry to START.
REQ-030 Enable_i=0 in any state SHALL force IDLE on the next clk.
- The partial frame is discarded, with no DataValid_o.
- Data_o and the error flags are unchanged.
REQ-031 ParityEn_i, ParityOdd_i and StopBits2_i SHALL be latched on entry to START.
- Changes mid-frame SHALL not affect the current frame.
REQ-032 A falling edge during DONE SHALL be ignored; detection resumes in IDLE.
REQ-033 Clks without AcqSig_i SHALL leave tick_cnt, BitIndex_o and the shift register unchanged.

Reset
REQ-034 rst=0 SHALL asynchronously set all of the following:
- State_o=IDLE, BitIndex_o=0, tick_cnt=0, rx_prev=1.
- Data_o=0, DataValid_o=0, ParityErr_o=0, FrameErr_o=0, Busy_o=0.
REQ-035 Reset mid-frame SHALL abort the frame with no DataValid_o, both during assertion and after release.
REQ-036 After release, the first falling edge SHALL be the one detected on the first tick with Rx_i=0.

Verification
REQ-037 8N1 frame, data 0xA5, OVERSAMPLE=16 -> one DataValid_o pulse 1 clk after the stop sample; Data_o=0xA5; both error flags 0.
REQ-038 Rx_i low for 4 ticks, then high -> START, then IDLE at tick 7; no DataValid_o; Data_o unchanged.
REQ-039 Even parity, data 0x03, parity bit 1 -> Data_o=0x03, ParityErr_o=1, FrameErr_o=0.
REQ-040 StopBits2_i=1, data 0x5A, second stop bit 0 -> Data_o=0x5A, FrameErr_o=1.
REQ-041 rst=0 while BitIndex_o=4 in DATA -> all outputs at reset values immediately; a following clean 0x3C frame is received correctly.
REQ-042 Enable_i=0 during PARITY -> IDLE on the next clk; no DataValid_o; previous Data_o retained.
